// File: rtl/ahb_slave_arb_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_arb_mux_if
// Brief    : Per-slave-port bundle between the AHB masters and the
//            slave-side arbiter/mux. Per-master signals are packed arrays
//            indexed by master number.
// Revision : 1.0 - initial release
// ============================================================================
interface ahb_slave_arb_mux_if #(
  parameter int CHANNEL_NUM  = 2,
  parameter int ADDR_PAYLOAD = 76,
  parameter int DATA_W       = 32
);
  localparam int HMW = $clog2(CHANNEL_NUM);

  // Master-side inputs to the arbiter/mux
  logic [CHANNEL_NUM-1:0]                   req;
  logic [CHANNEL_NUM-1:0]                   lock;
  logic [CHANNEL_NUM-1:0][1:0]              htrans_in;
  logic [CHANNEL_NUM-1:0][ADDR_PAYLOAD-1:0] addr_payload_in;
  logic [CHANNEL_NUM-1:0][DATA_W-1:0]       wdata_in;
  logic                                     hready_in;

  // Arbiter/mux outputs towards masters and slave
  logic [CHANNEL_NUM-1:0]                   hgrant;
  logic [HMW-1:0]                           hmaster;
  logic [1:0]                               htrans_out;
  logic [ADDR_PAYLOAD-1:0]                  addr_payload_out;
  logic [DATA_W-1:0]                        wdata_out;
  logic [HMW-1:0]                           data_master;
  logic                                     data_active;

  // View used by the arbiter/mux block
  modport slave (
    input  req, lock, htrans_in, addr_payload_in, wdata_in, hready_in,
    output hgrant, hmaster, htrans_out, addr_payload_out, wdata_out,
           data_master, data_active
  );

  // View used by whatever drives the masters' side
  modport master (
    output req, lock, htrans_in, addr_payload_in, wdata_in, hready_in,
    input  hgrant, hmaster, htrans_out, addr_payload_out, wdata_out,
           data_master, data_active
  );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slave_arb_mux
// Brief    : Slave-side AHB round-robin arbiter with split address-phase /
//            data-phase payload mux. The address phase follows the live
//            grant, write data follows the registered data-phase owner.
//            Optional tenure limit enabled by `define AHB_ARB_TENURE_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_arb_mux #(
  parameter int CHANNEL_NUM    = 2,
  parameter int ADDR_PAYLOAD   = 76,
  parameter int DATA_W         = 32,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 16
) (
  input wire                 hclk,
  input wire                 hreset,
  ahb_slave_arb_mux_if.slave bus
);

  localparam int             HMW     = $clog2(CHANNEL_NUM);
  localparam int             IW      = HMW + 1;
  localparam logic [HMW-1:0] DEF_IDX = HMW'(DEFAULT_MASTER);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Parameter legality is checked while elaborating
  generate
    if (DEFAULT_MASTER < 0 || DEFAULT_MASTER >= CHANNEL_NUM) begin : g_bad_default
      $error("ahb_slave_arb_mux: DEFAULT_MASTER out of range");
    end
    if (CHANNEL_NUM < 2 || CHANNEL_NUM > 16) begin : g_bad_channels
      $error("ahb_slave_arb_mux: CHANNEL_NUM must be 2..16");
    end
    if (MAX_TENURE < 1) begin : g_bad_tenure
      $error("ahb_slave_arb_mux: MAX_TENURE must be positive");
    end
  endgenerate

  logic [HMW-1:0]         hmaster_q;
  logic [HMW-1:0]         hmaster_d;
  logic [HMW-1:0]         data_master_q;
  logic                   data_active_q;

  logic [CHANNEL_NUM-1:0] grant_oh;
  logic [1:0]             cur_trans;
  logic                   cur_req;
  logic                   cur_lock;
  logic                   lock_eff;
  logic                   arb_point;
  logic [1:0]             htrans_sel;
  logic                   rr_found;
  logic [HMW-1:0]         rr_next;

  assign grant_oh   = CHANNEL_NUM'(1) << hmaster_q;
  assign cur_trans  = bus.htrans_in[hmaster_q];
  assign cur_req    = bus.req[hmaster_q];
  assign cur_lock   = bus.lock[hmaster_q];

  // A master that dropped its request presents IDLE regardless of its htrans
  assign htrans_sel = cur_req ? cur_trans : HTRANS_IDLE;

`ifdef AHB_ARB_TENURE_LIMIT_EN
  localparam int TW = $clog2(MAX_TENURE + 1);

  logic [TW-1:0] tenure_q;
  logic [TW-1:0] tenure_d;
  logic          tenure_expired;

  // Lock stops protecting the grant once the owner has used its tenure and
  // someone else is waiting; SEQ/BUSY still block so bursts stay intact.
  assign tenure_expired = (tenure_q >= TW'(MAX_TENURE)) && (|(bus.req & ~grant_oh));
  assign lock_eff       = cur_lock & ~tenure_expired;

  // Beat counter: restart on every grant change, saturate at the limit
  always_comb begin
    tenure_d = tenure_q;
    if (hmaster_d != hmaster_q) begin
      tenure_d = '0;
    end else if (bus.hready_in && htrans_sel[1] && (tenure_q != TW'(MAX_TENURE))) begin
      tenure_d = tenure_q + TW'(1);
    end
  end

  // Tenure counter register
  always_ff @(posedge hclk) begin
    if (hreset) begin
      tenure_q <= '0;
    end else begin
      tenure_q <= tenure_d;
    end
  end
`else
  assign lock_eff = cur_lock;
`endif

  assign arb_point = bus.hready_in
                   && (cur_trans != HTRANS_SEQ)
                   && (cur_trans != HTRANS_BUSY)
                   && !lock_eff;

  // Round-robin scan starting after the current owner, ending on it
  always_comb begin
    logic [IW-1:0] idx;
    idx      = '0;
    rr_found = 1'b0;
    rr_next  = DEF_IDX;
    for (int off = 1; off <= CHANNEL_NUM; off++) begin
      idx = {1'b0, hmaster_q} + IW'(off);
      if (idx >= IW'(CHANNEL_NUM)) begin
        idx = idx - IW'(CHANNEL_NUM);
      end
      if (!rr_found && bus.req[idx[HMW-1:0]]) begin
        rr_found = 1'b1;
        rr_next  = idx[HMW-1:0];
      end
    end
  end

  // Grant moves only at arbitration points; with no requester it parks
  always_comb begin
    hmaster_d = hmaster_q;
    if (arb_point) begin
      hmaster_d = rr_found ? rr_next : DEF_IDX;
    end
  end

  // Grant owner and data-phase owner; data phase advances only on hready
  always_ff @(posedge hclk) begin
    if (hreset) begin
      hmaster_q     <= DEF_IDX;
      data_master_q <= DEF_IDX;
      data_active_q <= 1'b0;
    end else begin
      hmaster_q <= hmaster_d;
      if (bus.hready_in) begin
        data_master_q <= hmaster_q;
        data_active_q <= htrans_sel[1];
      end
    end
  end

  assign bus.hgrant           = grant_oh;
  assign bus.hmaster          = hmaster_q;
  assign bus.htrans_out       = htrans_sel;
  assign bus.addr_payload_out = bus.addr_payload_in[hmaster_q];
  assign bus.wdata_out        = bus.wdata_in[data_master_q];
  assign bus.data_master      = data_master_q;
  assign bus.data_active      = data_active_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_slave_arb_mux
// Brief    : Directed, table-driven bench for ahb_slave_arb_mux with four
//            masters, plus hand-written lock/tenure and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_arb_mux;

  localparam int N  = 4;
  localparam int AP = 76;
  localparam int DW = 32;

  logic hclk;
  logic hreset;
  int   n_vec;
  int   n_err;

  ahb_slave_arb_mux_if #(.CHANNEL_NUM(N), .ADDR_PAYLOAD(AP), .DATA_W(DW)) bus ();

  ahb_slave_arb_mux #(
    .CHANNEL_NUM   (N),
    .ADDR_PAYLOAD  (AP),
    .DATA_W        (DW),
    .DEFAULT_MASTER(0),
    .MAX_TENURE    (16)
  ) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [7:0] htr;    // {h3,h2,h1,h0}
    logic       rdy;
    logic [1:0] e_out;  // htrans_out before the edge
    logic [1:0] e_hm;   // hmaster after the edge
    logic [1:0] e_dm;   // data_master after the edge
    logic       e_da;   // data_active after the edge
  } vec_t;

  vec_t vt[$];

  function automatic logic [AP-1:0] pay(input int m);
    pay = {12'hA5A, 64'h0123_4567_89AB_CDE0 + 64'(m)};
  endfunction

  function automatic logic [DW-1:0] wd(input int m);
    wd = 32'hD00D_0000 + 32'(m);
  endfunction

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l, input logic [7:0] h,
                              input logic y, input logic [1:0] eo, input logic [1:0] ehm,
                              input logic [1:0] edm, input logic eda);
    vec_t v;
    v.req = r; v.lock = l; v.htr = h; v.rdy = y;
    v.e_out = eo; v.e_hm = ehm; v.e_dm = edm; v.e_da = eda;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [7:0] h, input logic y);
    bus.req       = r;
    bus.lock      = l;
    bus.htrans_in = h;
    bus.hready_in = y;
  endtask

  initial begin
    int prev_hm;
    int prev_dm;
    logic [1:0] exp_hm;

    n_vec = 0;
    n_err = 0;
    hreset = 1'b1;
    drive(4'b0000, 4'b0000, 8'h00, 1'b1);
    for (int m = 0; m < N; m++) begin
      bus.addr_payload_in[m] = pay(m);
      bus.wdata_in[m]        = wd(m);
    end

    // Round robin with all masters requesting, wait states after first grant move
    vt.push_back(mk(4'hF, 4'h0, 8'hAA, 1'b1, 2'b10, 2'd1, 2'd0, 1'b1));
    vt.push_back(mk(4'hF, 4'h0, 8'hAA, 1'b0, 2'b10, 2'd1, 2'd0, 1'b1));
    vt.push_back(mk(4'hF, 4'h0, 8'hAA, 1'b0, 2'b10, 2'd1, 2'd0, 1'b1));
    vt.push_back(mk(4'hF, 4'h0, 8'hAA, 1'b0, 2'b10, 2'd1, 2'd0, 1'b1));
    vt.push_back(mk(4'hF, 4'h0, 8'hAA, 1'b1, 2'b10, 2'd2, 2'd1, 1'b1));
    vt.push_back(mk(4'hF, 4'h0, 8'hAA, 1'b1, 2'b10, 2'd3, 2'd2, 1'b1));
    vt.push_back(mk(4'hF, 4'h0, 8'hAA, 1'b1, 2'b10, 2'd0, 2'd3, 1'b1));
    vt.push_back(mk(4'hF, 4'h0, 8'hAA, 1'b1, 2'b10, 2'd1, 2'd0, 1'b1));
    // Owner 1 dropped req: htrans forced IDLE, grant goes to master 0
    vt.push_back(mk(4'h1, 4'h0, 8'hAA, 1'b1, 2'b00, 2'd0, 2'd1, 1'b0));
    // Burst on master 0: NONSEQ with only itself requesting, then SEQ/BUSY/SEQ
    vt.push_back(mk(4'h1, 4'h0, 8'h02, 1'b1, 2'b10, 2'd0, 2'd0, 1'b1));
    vt.push_back(mk(4'h3, 4'h0, 8'h0B, 1'b1, 2'b11, 2'd0, 2'd0, 1'b1));
    vt.push_back(mk(4'h3, 4'h0, 8'h09, 1'b1, 2'b01, 2'd0, 2'd0, 1'b0));
    vt.push_back(mk(4'h3, 4'h0, 8'h0B, 1'b0, 2'b11, 2'd0, 2'd0, 1'b0));
    vt.push_back(mk(4'h3, 4'h0, 8'h0B, 1'b0, 2'b11, 2'd0, 2'd0, 1'b0));
    vt.push_back(mk(4'h3, 4'h0, 8'h0B, 1'b0, 2'b11, 2'd0, 2'd0, 1'b0));
    vt.push_back(mk(4'h3, 4'h0, 8'h0B, 1'b1, 2'b11, 2'd0, 2'd0, 1'b1));
    vt.push_back(mk(4'h3, 4'h0, 8'h0B, 1'b1, 2'b11, 2'd0, 2'd0, 1'b1));
    // Burst over: grant moves to master 1 on the next edge
    vt.push_back(mk(4'h2, 4'h0, 8'h08, 1'b1, 2'b00, 2'd1, 2'd0, 1'b0));
    // No requests: park on the default master
    vt.push_back(mk(4'h0, 4'h0, 8'h00, 1'b1, 2'b00, 2'd0, 2'd1, 1'b0));

    // Reset state
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b0;
    chk("reset.hgrant", bus.hgrant, 4'b0001);
    chk("reset.hmaster", bus.hmaster, 2'd0);
    chk("reset.data_master", bus.data_master, 2'd0);
    chk("reset.data_active", bus.data_active, 1'b0);
    chk("reset.htrans_out", bus.htrans_out, 2'b00);

    prev_hm = 0;
    prev_dm = 0;
    foreach (vt[i]) begin
      drive(vt[i].req, vt[i].lock, vt[i].htr, vt[i].rdy);
      #1;
      chk($sformatf("v%0d.htrans_out", i), bus.htrans_out, vt[i].e_out);
      chk($sformatf("v%0d.addr_payload_out", i), bus.addr_payload_out, pay(prev_hm));
      chk($sformatf("v%0d.wdata_out", i), bus.wdata_out, wd(prev_dm));
      edge_wait();
      chk($sformatf("v%0d.hmaster", i), bus.hmaster, vt[i].e_hm);
      chk($sformatf("v%0d.hgrant", i), bus.hgrant, 4'b0001 << vt[i].e_hm);
      chk($sformatf("v%0d.data_master", i), bus.data_master, vt[i].e_dm);
      chk($sformatf("v%0d.data_active", i), bus.data_active, vt[i].e_da);
      prev_hm = int'(vt[i].e_hm);
      prev_dm = int'(vt[i].e_dm);
    end

    // Locked master 0 issuing 20 NONSEQ singles while master 1 waits
    drive(4'h3, 4'h1, 8'h0A, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      edge_wait();
`ifdef AHB_ARB_TENURE_LIMIT_EN
      exp_hm = (k == 17) ? 2'd1 : 2'd0;
`else
      exp_hm = 2'd0;
`endif
      chk($sformatf("lock.beat%0d.hmaster", k), bus.hmaster, exp_hm);
      chk($sformatf("lock.beat%0d.data_active", k), bus.data_active, 1'b1);
    end

    // INCR8 on master 2 interrupted by reset
    drive(4'h4, 4'h0, 8'h00, 1'b1);
    edge_wait();
    chk("incr8.grant.hmaster", bus.hmaster, 2'd2);
    drive(4'h4, 4'h0, 8'h20, 1'b1);
    edge_wait();
    chk("incr8.nseq.hmaster", bus.hmaster, 2'd2);
    chk("incr8.nseq.data_active", bus.data_active, 1'b1);
    drive(4'h5, 4'h0, 8'h30, 1'b1);
    for (int k = 0; k < 2; k++) begin
      edge_wait();
      chk($sformatf("incr8.seq%0d.hmaster", k), bus.hmaster, 2'd2);
      chk($sformatf("incr8.seq%0d.data_master", k), bus.data_master, 2'd2);
    end
    hreset = 1'b1;
    edge_wait();
    chk("midreset.hgrant", bus.hgrant, 4'b0001);
    chk("midreset.hmaster", bus.hmaster, 2'd0);
    chk("midreset.data_master", bus.data_master, 2'd0);
    chk("midreset.data_active", bus.data_active, 1'b0);
    hreset = 1'b0;
    drive(4'h5, 4'h0, 8'h22, 1'b1);
    #1;
    chk("postreset.htrans_out", bus.htrans_out, 2'b10);
    chk("postreset.wdata_out", bus.wdata_out, wd(0));
    edge_wait();
    chk("postreset.hmaster", bus.hmaster, 2'd2);
    chk("postreset.data_master", bus.data_master, 2'd0);
    chk("postreset.data_active", bus.data_active, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
